mul16_seq_ctrl: RTL and testbench

MUL16_SEQ_CTRL -- requirements
Module: mul16_seq_ctrl

---
 rtl/mul16_seq_ctrl.sv | 80 ++++++++
 tb/tb_mul16_seq_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mul16_seq_ctrl.sv
// mul16_seq_ctrl: 16x16 unsigned sequential multiplier sharing one 8x8 multiplier over four steps.
// Optional MUL_SEQ_ZERO_SKIP_EN: a zero operand jumps straight to DONE with p=0.
module mul8x8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  assign o_p = i_a * i_b;
endmodule

module mul16_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_step;
  logic [15:0] r_a, r_b;
  logic [31:0] r_acc, r_p;
  logic [7:0]  w_op_a, w_op_b;
  logic [15:0] w_pp;
  logic [31:0] w_pp_sh, w_sum;
  logic        w_accept, w_zero;
  assign w_accept = in_valid && (r_state == IDLE);
`ifdef MUL_SEQ_ZERO_SKIP_EN
  assign w_zero = (a == 16'd0) || (b == 16'd0);
`else
  assign w_zero = 1'b0;
`endif
  // step[0] picks the high byte of a, step[1] the high byte of b
  assign w_op_a  = r_step[0] ? r_a[15:8] : r_a[7:0];
  assign w_op_b  = r_step[1] ? r_b[15:8] : r_b[7:0];
  assign w_pp_sh = (r_step == 2'd3) ? {w_pp, 16'd0} :
                   (r_step == 2'd0) ? {16'd0, w_pp} : {8'd0, w_pp, 8'd0};
  assign w_sum   = r_acc + w_pp_sh;
  mul8x8 u_mul (.i_a(w_op_a), .i_b(w_op_b), .o_p(w_pp));
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = w_accept                                ? (w_zero ? DONE : MUL) :
             (r_state == MUL && r_step == 2'd3)      ? DONE :
             (r_state == DONE && out_ready)          ? IDLE : r_state;
  end
  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state != IDLE);
    out_valid = (r_state == DONE);
    p         = r_p;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= 2'd0;
      r_acc  <= 32'd0;
      r_p    <= 32'd0;
      r_a    <= 16'd0;
      r_b    <= 16'd0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_acc  <= 32'd0;
      r_step <= 2'd0;
      if (w_zero) r_p <= 32'd0;
    end else if (r_state == MUL) begin
      r_acc  <= w_sum;
      r_step <= r_step + 2'd1;
      if (r_step == 2'd3) r_p <= w_sum;
    end
  end
endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// tb_mul16_seq_ctrl: directed self-checking bench for mul16_seq_ctrl.
module tb_mul16_seq_ctrl;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b;
  logic [31:0] p;
  int vec = 0;
  int errs = 0;
`ifdef MUL_SEQ_ZERO_SKIP_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 4;
`endif

  mul16_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] x, input logic [15:0] y);
    a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; a = 16'h0007; b = 16'h0009; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vec++; if (p !== 32'd0) begin errs++; $display("FAIL reset_p got %h want 0", p); end
  endtask

  task automatic test_basic;
    int n;
    out_ready = 1'b1;
    accept(16'h1234, 16'h5678);
    vec++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL basic_mul_flags got ready=%b busy=%b want 0/1", in_ready, busy); end
    wait_done(n);
    vec++; if (n !== 4) begin errs++; $display("FAIL basic_latency got %0d want 4", n); end
    vec++; if (p !== 32'h06260060) begin errs++; $display("FAIL basic_p got %h want 06260060", p); end
    tick();
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_pulse got %b want 0", out_valid); end
    vec++; if (p !== 32'h06260060 || in_ready !== 1'b1) begin errs++; $display("FAIL basic_after got p=%h ready=%b want 06260060/1", p, in_ready); end
  endtask

  task automatic test_max;
    int n;
    out_ready = 1'b1;
    accept(16'hFFFF, 16'hFFFF);
    wait_done(n);
    vec++; if (n !== 4) begin errs++; $display("FAIL max_latency got %0d want 4", n); end
    vec++; if (p !== 32'hFFFE0001) begin errs++; $display("FAIL max_p got %h want fffe0001", p); end
    tick();
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    accept(16'h00FF, 16'h0100);
    wait_done(n);
    vec++; if (n !== 4) begin errs++; $display("FAIL bp_latency got %0d want 4", n); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if (out_valid !== 1'b1 || p !== 32'h0000FF00) begin errs++; $display("FAIL bp_hold%0d got v=%b p=%h want 1/0000ff00", i, out_valid, p); end
    end
    out_ready = 1'b1;
    tick();
    vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL bp_deliver got v=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_ignore_busy;
    out_ready = 1'b0;
    a = 16'h0002; b = 16'h0003; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      a = 16'h1111 * 16'(i + 1); b = 16'h2222 + 16'(i);
      vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL busy_ready%0d got %b want 0", i, in_ready); end
      tick();
    end
    vec++; if (out_valid !== 1'b1 || p !== 32'd6) begin errs++; $display("FAIL busy_result got v=%b p=%h want 1/00000006", out_valid, p); end
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL busy_done_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    tick();
    vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errs++; $display("FAIL busy_no_accept_on_deliver got busy=%b v=%b want 0/0", busy, out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight;
    int n;
    out_ready = 1'b1;
    accept(16'h1234, 16'h5678);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++; if (out_valid !== 1'b0 || p !== 32'd0 || in_ready !== 1'b1) begin errs++; $display("FAIL midrst got v=%b p=%h ready=%b want 0/0/1", out_valid, p, in_ready); end
    accept(16'h0003, 16'h0005);
    wait_done(n);
    vec++; if (n !== 4 || p !== 32'h0000000F) begin errs++; $display("FAIL midrst_after got n=%0d p=%h want 4/0000000f", n, p); end
    tick();
  endtask

  task automatic test_zero;
    int n;
    out_ready = 1'b1;
    accept(16'h0000, 16'hABCD);
    wait_done(n);
    vec++; if (n !== ZLAT) begin errs++; $display("FAIL zero_latency got %0d want %0d", n, ZLAT); end
    vec++; if (p !== 32'd0) begin errs++; $display("FAIL zero_p got %h want 0", p); end
    tick();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 16'd0; b = 16'd0;
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_ignore_busy();
    test_reset_midflight();
    test_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
